// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage feeding the control unit. Holds the PC, issues one
//   word fetch at a time over a req/ready + rvalid handshake, and registers the
//   fetched word with its PC into the IF/ID register (if_inst[31:22] is the
//   10-bit instruction header). Handles decode stall and execute redirect.
//
//   Optional build macro FETCH_PERF_CNT_EN adds two saturating performance
//   counters: perf_fetched and perf_killed.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_killed
`endif
);

    // REQ: request on the bus; WAIT: one fetch outstanding; HOLD: a response
    // arrived during a stall and is parked in the hold buffer.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                kill_q, kill_d;

    logic                if_valid_q, if_valid_d;
    logic [INST_W-1:0]   if_inst_q, if_inst_d;
    logic [ADDR_W-1:0]   if_pc_q, if_pc_d;

    logic                buf_valid_q, buf_valid_d;
    logic [INST_W-1:0]   buf_inst_q, buf_inst_d;
    logic [ADDR_W-1:0]   buf_pc_q, buf_pc_d;

    logic [ADDR_W-1:0]   pc_plus4;
    logic                redirect_kills;

    // Sequential PC increment; wraps naturally modulo 2^ADDR_W.
    assign pc_plus4 = pc_q + ADDR_W'(4);

    // A redirect must squash the in-flight fetch if one is outstanding after
    // this edge: either we are already waiting (and the response is not
    // arriving right now), or the memory accepts a request this very cycle.
    // A response landing in the same cycle as the redirect simply gets dropped,
    // so there is nothing left to kill.
    assign redirect_kills = ((state_q == S_WAIT) && !imem_rvalid) ||
                            ((state_q == S_REQ)  && imem_ready);

    // Next-state logic: FSM, PC, IF/ID register and hold buffer.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        if_valid_d  = if_valid_q;
        if_inst_d   = if_inst_q;
        if_pc_d     = if_pc_q;
        buf_valid_d = buf_valid_q;
        buf_inst_d  = buf_inst_q;
        buf_pc_d    = buf_pc_q;

        // With stall low, decode consumes the word currently in IF/ID.
        if (!stall) begin
            if_valid_d = 1'b0;
        end

        if (branch_taken) begin
            pc_d        = branch_target;
            if_valid_d  = 1'b0;
            buf_valid_d = 1'b0;
            if (redirect_kills) begin
                kill_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                kill_d  = 1'b0;
                state_d = S_REQ;
            end
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                        if (kill_q) begin
                            // Stale response from before a redirect; pc
                            // already holds the redirect target.
                            kill_d = 1'b0;
                        end else if (!stall) begin
                            if_valid_d = 1'b1;
                            if_inst_d  = imem_rdata;
                            if_pc_d    = pc_q;
                            pc_d       = pc_plus4;
                        end else begin
                            buf_valid_d = 1'b1;
                            buf_inst_d  = imem_rdata;
                            buf_pc_d    = pc_q;
                            pc_d        = pc_plus4;
                            state_d     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        if_valid_d  = 1'b1;
                        if_inst_d   = buf_inst_q;
                        if_pc_d     = buf_pc_q;
                        buf_valid_d = 1'b0;
                        state_d     = S_REQ;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end
    end

    // State register for the FSM, PC, IF/ID register and hold buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of block order.
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            if_valid_q  <= 1'b0;
            if_inst_q   <= '0;
            if_pc_q     <= '0;
            buf_valid_q <= 1'b0;
            // NOTE: the buffer payload is qualified by buf_valid_q, so clearing
            // it is not needed for correctness; it is reset anyway so the
            // whole stage powers up in a known state.
            buf_inst_q  <= '0;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            if_valid_q  <= if_valid_d;
            if_inst_q   <= if_inst_d;
            if_pc_q     <= if_pc_d;
            buf_valid_q <= buf_valid_d;
            buf_inst_q  <= buf_inst_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    // Memory request is suppressed while reset is asserted.
    assign imem_req  = (state_q == S_REQ) && !rst;
    assign imem_addr = pc_q;

    assign if_valid  = if_valid_q;
    assign if_inst   = if_inst_q;
    assign if_pc     = if_pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic        fetch_evt;
    logic        kill_evt;
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_killed_q;

    // A response is fetched when it lands in IF/ID or the hold buffer; it is
    // killed when discarded, or when a redirect throws away a live word.
    assign fetch_evt = !branch_taken && (state_q == S_WAIT) && imem_rvalid && !kill_q;
    assign kill_evt  = ((state_q == S_WAIT) && imem_rvalid && (kill_q || branch_taken)) ||
                       (branch_taken && (if_valid_q || buf_valid_q));

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_killed_q  <= '0;
        end else begin
            if (fetch_evt && (perf_fetched_q != '1)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (kill_evt && (perf_killed_q != '1)) begin
                perf_killed_q <= perf_killed_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_killed  = perf_killed_q;
`else
    // Performance counters not built: no extra ports or state.
`endif

    // A response may only arrive while a fetch is outstanding.
    a_rvalid_in_wait: assert property (
        @(posedge clk) disable iff (rst) imem_rvalid |-> (state_q == S_WAIT)
    );

endmodule
